// File: rtl/ddr2_wr_pkg.sv
// Shared definitions for the DDR2 write-burst scheduler: FSM encoding,
// MIG command codes and the MIG address width.
package ddr2_wr_pkg;

    localparam int APP_ADDR_W = 31;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CMD   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/wr_burst_addr_gen.sv
// MIG command address register: loads the base address, steps per command and
// wraps back to the base once the next step would reach the exclusive limit.
module wr_burst_addr_gen
    import ddr2_wr_pkg::*;
#(
    parameter int                    ADDR_STEP  = 4,
    parameter logic [APP_ADDR_W-1:0] ADDR_LIMIT = 31'h0100_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample,
    input  logic                  load,
    input  logic                  step,
    input  logic [APP_ADDR_W-1:0] base_addr,
    output logic [APP_ADDR_W-1:0] addr
);

    localparam logic [APP_ADDR_W:0] STEP_EXT  = (APP_ADDR_W + 1)'(ADDR_STEP);
    localparam logic [APP_ADDR_W:0] LIMIT_EXT = {1'b0, ADDR_LIMIT};

    logic [APP_ADDR_W-1:0] base_q;
    logic [APP_ADDR_W:0]   addr_sum;

    // One extra bit so the limit compare cannot be fooled by overflow.
    assign addr_sum = {1'b0, addr} + STEP_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            addr   <= '0;
        end else begin
            if (sample) begin
                base_q <= base_addr;
            end
            if (load) begin
                addr <= base_addr;
            end else if (step) begin
                if (addr_sum >= LIMIT_EXT) begin
                    addr <= base_q;
                end else begin
                    addr <= addr_sum[APP_ADDR_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ddr2_wr_burst_ctrl.sv
// Drains fixed-size bursts from the write FIFO into the MIG write-data FIFO,
// then issues the matching BL4 write commands. Optional WR_BURST_STATS_EN adds counters.
//
// state    | meaning
// ST_IDLE  | waiting for calibration, enable, a full burst and MIG room
// ST_READ  | issuing WRITE_BURST FIFO reads, paused by app_wdf_afull
// ST_DRAIN | waiting for the in-flight words to reach the MIG data FIFO
// ST_CMD   | issuing WRITE_BURST/2 write commands, paused by app_af_afull
module ddr2_wr_burst_ctrl
    import ddr2_wr_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    WRITE_BURST = 8,
    parameter int                    ADDR_STEP   = 4,
    parameter logic [APP_ADDR_W-1:0] ADDR_LIMIT  = 31'h0100_0000
) (
    input  logic                    rd_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [APP_ADDR_W-1:0]   base_addr,
    input  logic                    phy_init_done,
    input  logic [9:0]              rd_data_count,
    input  logic [DATA_WIDTH-1:0]   data_out,
    input  logic                    dout_vd,
    output logic                    rd_fifo,
    output logic                    app_wdf_wren,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask_data,
    input  logic                    app_wdf_afull,
    output logic                    app_af_wren,
    output logic [2:0]              app_af_cmd,
    output logic [APP_ADDR_W-1:0]   app_af_addr,
    input  logic                    app_af_afull,
    output logic                    busy,
    output logic                    burst_done
`ifdef WR_BURST_STATS_EN
    ,
    output logic [31:0]             burst_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int            CW       = $clog2(WRITE_BURST) + 1;
    localparam logic [CW-1:0] BURST_N  = CW'(WRITE_BURST);
    localparam logic [CW-1:0] RD_LAST  = CW'(WRITE_BURST - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(WRITE_BURST / 2 - 1);
    localparam logic [9:0]    FILL_MIN = 10'(WRITE_BURST);

    wr_state_t             state;
    logic [CW-1:0]         rd_issued;
    logic [CW-1:0]         wr_done;
    logic [CW-1:0]         cmd_cnt;
    logic                  addr_loaded;
    logic [APP_ADDR_W-1:0] addr_q;
    logic                  idle;
    logic                  start_ok;
    logic                  cmd_go;

    assign idle     = (state == ST_IDLE);
    // burst_done in the gate guarantees one idle cycle between bursts.
    assign start_ok = idle && phy_init_done && enable && !burst_done &&
                      (rd_data_count >= FILL_MIN) && !app_wdf_afull && !app_af_afull;
    // The first command goes out on the DRAIN exit edge to keep the unstalled burst tight.
    assign cmd_go   = !app_af_afull &&
                      ((state == ST_CMD) || ((state == ST_DRAIN) && (wr_done == BURST_N)));

    assign app_af_cmd        = APP_CMD_WRITE;
    assign app_wdf_mask_data = '0;
    assign busy              = !idle;

    wr_burst_addr_gen #(
        .ADDR_STEP  (ADDR_STEP),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_addr_gen (
        .clk       (rd_clk),
        .rst       (reset),
        .sample    (idle),
        .load      (start_ok && !addr_loaded),
        .step      (cmd_go),
        .base_addr (base_addr),
        .addr      (addr_q)
    );

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rd_issued    <= '0;
            wr_done      <= '0;
            cmd_cnt      <= '0;
            addr_loaded  <= 1'b0;
            rd_fifo      <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_af_wren  <= 1'b0;
            app_af_addr  <= '0;
            burst_done   <= 1'b0;
        end else begin
            rd_fifo      <= 1'b0;
            app_af_wren  <= 1'b0;
            burst_done   <= 1'b0;
            app_wdf_wren <= dout_vd;
            if (dout_vd) begin
                app_wdf_data <= data_out;
            end
            if (app_wdf_wren && !idle) begin
                wr_done <= wr_done + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state       <= ST_READ;
                        rd_fifo     <= 1'b1;
                        rd_issued   <= CW'(1);
                        wr_done     <= '0;
                        cmd_cnt     <= '0;
                        addr_loaded <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (!app_wdf_afull) begin
                        rd_fifo   <= 1'b1;
                        rd_issued <= rd_issued + 1'b1;
                        if (rd_issued == RD_LAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cmd_go) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD: ;
                default: state <= ST_IDLE;
            endcase

            if (cmd_go) begin
                app_af_wren <= 1'b1;
                app_af_addr <= addr_q;
                cmd_cnt     <= cmd_cnt + 1'b1;
                if (cmd_cnt == CMD_LAST) begin
                    burst_done <= 1'b1;
                    state      <= ST_IDLE;
                end
            end
        end
    end

`ifdef WR_BURST_STATS_EN
    logic stalled;

    assign stalled = ((state == ST_READ) && app_wdf_afull) ||
                     ((state == ST_CMD) && app_af_afull);

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (burst_done && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (stalled && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_wr_burst_ctrl.sv
// Self-checking bench for ddr2_wr_burst_ctrl with a burst-level reference model
// and directed scenarios (idle gating, back-pressure, address wrap, reset).
module tb_ddr2_wr_burst_ctrl;

    localparam int          DW    = 64;
    localparam int          WB    = 8;
    localparam int          STEP  = 4;
    localparam logic [30:0] LIMIT = 31'h110;

    logic          rd_clk;
    logic          reset;
    logic          enable;
    logic [30:0]   base_addr;
    logic          phy_init_done;
    logic [9:0]    rd_data_count;
    logic [DW-1:0] data_out;
    logic          dout_vd;
    logic          rd_fifo;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask_data;
    logic          app_wdf_afull;
    logic          app_af_wren;
    logic [2:0]    app_af_cmd;
    logic [30:0]   app_af_addr;
    logic          app_af_afull;
    logic          busy;
    logic          burst_done;
`ifdef WR_BURST_STATS_EN
    logic [31:0]   burst_cnt;
    logic [31:0]   stall_cnt;
`endif

    ddr2_wr_burst_ctrl #(
        .DATA_WIDTH  (DW),
        .WRITE_BURST (WB),
        .ADDR_STEP   (STEP),
        .ADDR_LIMIT  (LIMIT)
    ) dut (
        .rd_clk            (rd_clk),
        .reset             (reset),
        .enable            (enable),
        .base_addr         (base_addr),
        .phy_init_done     (phy_init_done),
        .rd_data_count     (rd_data_count),
        .data_out          (data_out),
        .dout_vd           (dout_vd),
        .rd_fifo           (rd_fifo),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask_data (app_wdf_mask_data),
        .app_wdf_afull     (app_wdf_afull),
        .app_af_wren       (app_af_wren),
        .app_af_cmd        (app_af_cmd),
        .app_af_addr       (app_af_addr),
        .app_af_afull      (app_af_afull),
        .busy              (busy),
        .burst_done        (burst_done)
`ifdef WR_BURST_STATS_EN
        ,
        .burst_cnt         (burst_cnt),
        .stall_cnt         (stall_cnt)
`endif
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // FIFO read side: data appears one cycle after an accepted rd_fifo.
    bit pend;
    int wptr = 0;
    initial begin
        dout_vd  = 1'b0;
        data_out = '0;
        forever begin
            @(negedge rd_clk);
            pend = rd_fifo;
            @(posedge rd_clk);
            #1;
            dout_vd = pend;
            if (pend) begin
                data_out = {32'hC0DE_0000 | 32'(wptr), 32'(wptr) * 32'd3};
                wptr++;
            end
        end
    end

    // Burst-level reference model and per-cycle compare.
    int          cyc = 0;
    int          n_start = 0, n_done = 0;
    int          dec_cyc = 0, done_cyc = 0, first_rd = -1, last_rd = 0;
    int          rd_n = 0, wr_n = 0, cmd_n = 0;
    bit          stalled = 0, loaded = 0;
    logic [30:0] m_addr = '0;
    logic [30:0] got_addr [4];
    bit          p_reset = 1, p_dout_vd = 0, p_wdf_afull = 0, p_af_afull = 0;
    bit          p_done = 0, p_busy = 0, p_start_ok = 0;
    logic [DW-1:0] p_data = '0;

    always @(negedge rd_clk) begin
        cyc++;
        if (reset) begin
            check("reset_outputs",
                  {rd_fifo, app_wdf_wren, app_af_wren, busy, burst_done,
                   |app_af_addr, |app_wdf_data}, '0);
            loaded = 0;
            rd_n = 0; wr_n = 0; cmd_n = 0;
            p_reset = 1;
        end else begin
            check("af_cmd_write", app_af_cmd, 3'b000);
            check("wdf_mask_zero", app_wdf_mask_data, '0);
            if (!p_reset) begin
                check("wdf_wren_follows_vd", app_wdf_wren, p_dout_vd);
                if (app_wdf_wren) check("wdf_data", app_wdf_data, p_data);
            end
            if (busy && !p_busy) begin
                n_start++;
                check("start_conditions", p_start_ok, 1'b1);
                dec_cyc = cyc - 1;
                rd_n = 0; wr_n = 0; cmd_n = 0;
                first_rd = -1;
                stalled = 0;
                if (!loaded) begin
                    m_addr = base_addr;
                    loaded = 1;
                end
            end
            if (busy && (app_wdf_afull || app_af_afull)) stalled = 1;
            if (app_wdf_wren && busy) wr_n++;
            if (rd_fifo) begin
                check("rd_after_wdf_afull", p_wdf_afull, 1'b0);
                check("rd_gap_after_done", p_done, 1'b0);
                rd_n++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (app_af_wren) begin
                check("cmd_after_af_afull", p_af_afull, 1'b0);
                check("cmd_addr", app_af_addr, m_addr);
                if (cmd_n < 4) got_addr[cmd_n] = app_af_addr;
                cmd_n++;
                if (int'(m_addr) + STEP >= int'(LIMIT)) m_addr = base_addr;
                else m_addr = m_addr + 31'(STEP);
            end
            if (burst_done) begin
                check("burst_rd_count", rd_n, WB);
                check("burst_wdf_count", wr_n, WB);
                check("burst_cmd_count", cmd_n, WB / 2);
                check("done_with_last_cmd", app_af_wren, 1'b1);
                if (!stalled) check("burst_len", cyc - dec_cyc, WB + 3 + WB / 2);
                done_cyc = cyc;
                n_done++;
            end
            p_reset = 0;
        end
        p_dout_vd   = dout_vd;
        p_data      = data_out;
        p_wdf_afull = app_wdf_afull;
        p_af_afull  = app_af_afull;
        p_done      = burst_done;
        p_busy      = busy;
        p_start_ok  = phy_init_done && enable && (int'(rd_data_count) >= WB) &&
                      !app_wdf_afull && !app_af_afull;
    end

    task automatic step_cycles(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_start(input int target, input string name);
        int k = 0;
        while (n_start < target && k < 200) begin
            @(negedge rd_clk); #1; k++;
        end
        if (n_start < target) timeout_fail(name);
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (n_done < target && k < 200) begin
            @(negedge rd_clk); #1; k++;
        end
        if (n_done < target) timeout_fail(name);
    endtask

    task automatic check_addrs(input string name, input logic [30:0] a0);
        logic [30:0] exp [4];
        exp[0] = a0;
        exp[1] = a0 + 31'h4;
        exp[2] = a0 + 31'h8;
        exp[3] = a0 + 31'hC;
        for (int i = 0; i < 4; i++) check(name, got_addr[i], exp[i]);
    endtask

    int d_prev;
    int k;

    initial begin
        reset = 1'b1; enable = 1'b0; phy_init_done = 1'b0; base_addr = 31'h100;
        rd_data_count = '0; app_wdf_afull = 1'b0; app_af_afull = 1'b0;
        step_cycles(3);
        reset = 1'b0;

        // One word short of a burst: nothing starts.
        phy_init_done = 1'b1; enable = 1'b1; rd_data_count = 10'd7;
        step_cycles(20);
        check("idle_count7_starts", n_start, 0);
        check("idle_count7_busy", busy, 1'b0);

        // Plenty of data but no calibration.
        phy_init_done = 1'b0; rd_data_count = 10'd20;
        step_cycles(20);
        check("idle_nophy_starts", n_start, 0);
        check("idle_nophy_rd", rd_fifo, 1'b0);

        // Base burst; enable drops mid-burst and the burst still completes.
        phy_init_done = 1'b1; rd_data_count = 10'd8;
        wait_start(1, "base_start");
        enable = 1'b0;
        wait_done(1, "base_done");
        check("base_len", done_cyc - dec_cyc, 15);
        check("base_first_rd", first_rd - dec_cyc, 1);
        check("base_rd_span", last_rd - first_rd, 7);
        check_addrs("base_addr_seq", 31'h100);
        step_cycles(10);
        check("no_restart_enable_low", n_start, 1);

        // Back-to-back bursts; address wraps at 0x110 back to 0x100.
        enable = 1'b1;
        wait_done(2, "b2b_done2");
        d_prev = done_cyc;
        check_addrs("wrap_addr_seq2", 31'h100);
        wait_done(3, "b2b_done3");
        enable = 1'b0;
        check("b2b_gap", first_rd - d_prev, 2);
        check_addrs("wrap_addr_seq3", 31'h100);

        // app_wdf_afull held 5 cycles mid-READ.
        enable = 1'b1;
        wait_start(4, "wdf_afull_start");
        enable = 1'b0;
        k = 0;
        while (rd_n < 3 && k < 50) begin @(negedge rd_clk); #1; k++; end
        if (rd_n < 3) timeout_fail("wdf_afull_rd3");
        @(posedge rd_clk); #1;
        app_wdf_afull = 1'b1;
        step_cycles(5);
        app_wdf_afull = 1'b0;
        wait_done(4, "wdf_afull_done");
        check("wdf_afull_rd_span", last_rd - first_rd, 12);
        check("wdf_afull_len", done_cyc - dec_cyc, 20);

        // app_af_afull pulsed for 2 cycles during CMD.
        enable = 1'b1;
        wait_start(5, "af_afull_start");
        enable = 1'b0;
        k = 0;
        while (cmd_n < 1 && k < 50) begin @(negedge rd_clk); #1; k++; end
        if (cmd_n < 1) timeout_fail("af_afull_cmd1");
        @(posedge rd_clk); #1;
        app_af_afull = 1'b1;
        step_cycles(2);
        app_af_afull = 1'b0;
        wait_done(5, "af_afull_done");
        check("af_afull_len", done_cyc - dec_cyc, 17);
        check_addrs("af_afull_addr_seq", 31'h100);

        // Reset during READ, then a fresh burst from the new base.
        base_addr = 31'h0F0;
        enable = 1'b1;
        wait_start(6, "rst_start");
        k = 0;
        while (rd_n < 2 && k < 50) begin @(negedge rd_clk); #1; k++; end
        if (rd_n < 2) timeout_fail("rst_rd2");
        @(posedge rd_clk); #3;
        reset = 1'b1;
        #1;
        check("reset_mid_outputs",
              {rd_fifo, app_wdf_wren, app_af_wren, busy, burst_done}, '0);
        step_cycles(2);
        reset = 1'b0;
        wait_start(7, "post_rst_start");
        enable = 1'b0;
        wait_done(6, "post_rst_done");
        check_addrs("post_rst_addr_seq", 31'h0F0);
        check("post_rst_len", done_cyc - dec_cyc, 15);

        // Next burst continues from 0x100 rather than reloading the base.
        enable = 1'b1;
        wait_start(8, "cont_start");
        enable = 1'b0;
        wait_done(7, "cont_done");
        check_addrs("cont_addr_seq", 31'h100);

        step_cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
